// File: rtl/pulse_acq_pkg.sv
// pulse_acq shared definitions: frame header, FSM states,
// edge-mode encodings and frame length helper.
package pulse_acq_pkg;

  localparam logic [7:0] HDR0 = 8'hEB;
  localparam logic [7:0] HDR1 = 8'h90;
  localparam int HDR_BYTES = 10;

  localparam logic [1:0] EM_RISE = 2'b00;
  localparam logic [1:0] EM_FALL = 2'b01;
  localparam logic [1:0] EM_BOTH = 2'b10;
  localparam logic [1:0] EM_OFF  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SEND
  } state_t;

  function automatic int frame_len(
    input int num_ch,
    input int cnt_w,
    input bit cksum
  );
    return HDR_BYTES + num_ch * (cnt_w / 8) + (cksum ? 1 : 0);
  endfunction

endpackage

// File: rtl/pulse_acq_edge_det.sv
// pulse_edge_det: 2-flop synchroniser, edge register and
// mode-selected edge strobe for one pulse channel.
module pulse_edge_det
  import pulse_acq_pkg::*;
#(
  parameter logic [1:0] MODE = EM_RISE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pulse,
  output logic o_strobe
);

  // [0] sync1, [1] sync2, [2] previous sync2
  logic [2:0] r_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= '0;
    end else begin
      r_sh <= {r_sh[1:0], i_pulse};
    end
  end

  always_comb begin
    o_strobe = 1'b0;
    unique case (MODE)
      EM_RISE: o_strobe = r_sh[1] & ~r_sh[2];
      EM_FALL: o_strobe = ~r_sh[1] & r_sh[2];
      EM_BOTH: o_strobe = r_sh[1] ^ r_sh[2];
      default: o_strobe = 1'b0;
    endcase
  end

endmodule

// File: rtl/pulse_acq.sv
// pulse_acq: multi-channel pulse counter framing one window per tick
// into the UART TX FIFO; PULSE_ACQ_CKSUM_EN appends a checksum byte.
module pulse_acq
  import pulse_acq_pkg::*;
#(
  parameter logic [15:0]         VERSION    = 16'd0,
  parameter int                  NUM_CH     = 12,
  parameter int                  CNT_W      = 16,
  parameter logic [2*NUM_CH-1:0] EDGE_MODE  = '0,
  parameter int                  FIFO_DEPTH = 4096,
  parameter int                  USEDW_W    = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [NUM_CH-1:0]  pulse_in,
  input  logic [31:0]        count,
  input  logic               pulse_10ms,
  output logic               tx_fifo_wen,
  output logic [7:0]         tx_fifo_wdata,
  input  logic               tx_fifo_full,
  input  logic [USEDW_W-1:0] tx_fifo_usedw,
  output logic               busy,
  output logic [7:0]         drop_cnt
);

`ifdef PULSE_ACQ_CKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif
  localparam int NB        = CNT_W / 8;
  localparam int NPAY      = HDR_BYTES + NUM_CH * NB;
  localparam int PAY_W     = NPAY * 8;
  localparam int FRAME_LEN = frame_len(NUM_CH, CNT_W, CKS);
  localparam int IDX_W     = $clog2(FRAME_LEN + 1);

  logic [NUM_CH-1:0] w_stb;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [PAY_W-1:0]  r_shadow;
  logic [PAY_W-1:0]  w_load;
  logic [7:0]        r_seq;
  logic [7:0]        r_drop;
  logic [7:0]        w_byte;
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       w_free;
  state_t            r_state;
  state_t            w_next;
  logic              w_space;
  logic              w_last;
  logic              w_snap;
  logic              w_wr;
  logic              w_fail;
  logic              w_done;
  logic              w_late;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pulse_edge_det #(
      .MODE(EDGE_MODE[2*g +: 2])
    ) u_edge (
      .clk     (clk),
      .rst_n   (rst),
      .i_pulse (pulse_in[g]),
      .o_strobe(w_stb[g])
    );
  end

  // A strobe coinciding with the window close opens the next window at 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ena) begin
          r_cnt[i] <= '0;
        end else if (w_snap) begin
          r_cnt[i] <= {{(CNT_W-1){1'b0}}, w_stb[i]};
        end else if (w_stb[i] && r_cnt[i] != '1) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_load = '0;
    w_load[PAY_W-1 -: 80] = {HDR0, HDR1, VERSION, r_seq, r_drop, count};
    for (int i = 0; i < NUM_CH; i++) begin
      w_load[(NUM_CH-1-i)*CNT_W +: CNT_W] = r_cnt[i];
    end
  end

  assign w_free  = 32'(FIFO_DEPTH) - 32'(tx_fifo_usedw);
  assign w_space = w_free >= 32'(FRAME_LEN);
  assign w_last  = r_idx == IDX_W'(FRAME_LEN - 1);

`ifdef PULSE_ACQ_CKSUM_EN
  logic [7:0] r_ck;

  assign w_byte = (r_idx < IDX_W'(NPAY)) ? r_shadow[PAY_W-1 -: 8] : r_ck;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ck <= '0;
    end else if (w_snap) begin
      r_ck <= '0;
    end else if (w_wr && r_idx >= IDX_W'(2) && r_idx < IDX_W'(NPAY)) begin
      r_ck <= r_ck + w_byte;
    end
  end
`else
  assign w_byte = r_shadow[PAY_W-1 -: 8];
`endif

  // CHECK already writes byte 0 so the first strobe lands two cycles after the tick
  always_comb begin
    w_next = r_state;
    w_snap = 1'b0;
    w_wr   = 1'b0;
    w_fail = 1'b0;
    w_done = 1'b0;
    w_late = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (pulse_10ms) begin
          w_snap = 1'b1;
          w_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_late = pulse_10ms;
        if (w_space) begin
          w_wr   = !tx_fifo_full;
          w_next = ST_SEND;
        end else begin
          w_fail = 1'b1;
          w_next = ST_IDLE;
        end
      end
      ST_SEND: begin
        w_late = pulse_10ms;
        w_wr   = !tx_fifo_full;
        if (w_wr && w_last) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (!ena) begin
      w_next = ST_IDLE;
      w_snap = 1'b0;
      w_wr   = 1'b0;
      w_fail = 1'b0;
      w_done = 1'b0;
      w_late = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_shadow      <= '0;
      r_idx         <= '0;
      r_seq         <= '0;
      r_drop        <= '0;
      tx_fifo_wen   <= 1'b0;
      tx_fifo_wdata <= '0;
      busy          <= 1'b0;
    end else begin
      r_state     <= w_next;
      tx_fifo_wen <= w_wr;
      busy        <= w_wr || (w_next == ST_SEND);
      if (w_snap) begin
        r_shadow <= w_load;
        r_idx    <= '0;
      end else if (w_wr) begin
        r_shadow      <= r_shadow << 8;
        r_idx         <= r_idx + IDX_W'(1);
        tx_fifo_wdata <= w_byte;
      end
      if (w_fail || w_done) r_seq <= r_seq + 8'd1;
      r_drop <= r_drop + 8'(w_fail) + 8'(w_late);
    end
  end

  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_pulse_acq.sv
// tb_pulse_acq: random pulse windows checked against an event-count
// model; covers saturation, drops, stalls, late ticks and ena.
module tb_pulse_acq;

`ifdef PULSE_ACQ_CKSUM_EN
  localparam int FL = 15;
`else
  localparam int FL = 14;
`endif
  localparam logic [7:0] EM = 8'b11_10_01_00;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [3:0]  pulse_in;
  logic [31:0] count;
  logic        pulse_10ms;
  logic        tx_fifo_wen;
  logic [7:0]  tx_fifo_wdata;
  logic        tx_fifo_full;
  logic [11:0] tx_fifo_usedw;
  logic        busy;
  logic [7:0]  drop_cnt;

  int          n_chk;
  int          n_fail;
  int          rises [4];
  int          falls [4];
  logic [7:0]  exp_seq;
  logic [7:0]  exp_drop;
  logic [7:0]  exp_q [$];
  logic [7:0]  got [$];
  logic        full_s;

  pulse_acq #(
    .VERSION   (16'hA5C3),
    .NUM_CH    (4),
    .CNT_W     (8),
    .EDGE_MODE (EM),
    .FIFO_DEPTH(4096),
    .USEDW_W   (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .pulse_in     (pulse_in),
    .count        (count),
    .pulse_10ms   (pulse_10ms),
    .tx_fifo_wen  (tx_fifo_wen),
    .tx_fifo_wdata(tx_fifo_wdata),
    .tx_fifo_full (tx_fifo_full),
    .tx_fifo_usedw(tx_fifo_usedw),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    count = $urandom;
    forever begin
      @(negedge clk);
      count = count + 32'd13;
    end
  end

  initial full_s = 1'b0;
  always @(posedge clk) full_s <= tx_fifo_full;

  always @(negedge clk) begin
    if (rst && tx_fifo_wen) begin
      got.push_back(tx_fifo_wdata);
      check("wen_while_full", 32'(full_s), 32'd0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] expc(input int ch);
    logic [7:0] emv;
    logic [1:0] m;
    int v;
    emv = EM;
    m = emv[2*ch +: 2];
    case (m)
      2'b00:   v = rises[ch];
      2'b01:   v = falls[ch];
      2'b10:   v = rises[ch] + falls[ch];
      default: v = 0;
    endcase
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  task automatic clr_model();
    for (int c = 0; c < 4; c++) begin
      rises[c] = 0;
      falls[c] = 0;
    end
  endtask

  task automatic pulses(input int n, input logic [3:0] fix);
    logic [3:0] m;
    for (int k = 0; k < n; k++) begin
      m = (fix != 4'd0) ? fix : 4'($urandom);
      @(negedge clk); #1;
      pulse_in = pulse_in | m;
      for (int c = 0; c < 4; c++) if (m[c]) rises[c]++;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #1;
      pulse_in = pulse_in & ~m;
      for (int c = 0; c < 4; c++) if (m[c]) falls[c]++;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic tick(input logic [11:0] uw);
    logic [7:0] sum;
    @(negedge clk); #1;
    tx_fifo_usedw = uw;
    pulse_10ms = 1'b1;
    exp_q.delete();
    if (4096 - int'(uw) >= FL) begin
      exp_q.push_back(8'hEB);
      exp_q.push_back(8'h90);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'hC3);
      exp_q.push_back(exp_seq);
      exp_q.push_back(exp_drop);
      exp_q.push_back(count[31:24]);
      exp_q.push_back(count[23:16]);
      exp_q.push_back(count[15:8]);
      exp_q.push_back(count[7:0]);
      for (int c = 0; c < 4; c++) exp_q.push_back(expc(c));
`ifdef PULSE_ACQ_CKSUM_EN
      sum = 8'd0;
      for (int i = 2; i < exp_q.size(); i++) sum = sum + exp_q[i];
      exp_q.push_back(sum);
`endif
    end else begin
      exp_drop++;
      exp_seq++;
    end
    clr_model();
    @(negedge clk); #1;
    pulse_10ms = 1'b0;
  endtask

  task automatic wait_frame(input bit stall);
    int n;
    bit st;
    @(negedge clk); #1;
    check("first_wen_lat", 32'(tx_fifo_wen), 32'd1);
    check("busy_start", 32'(busy), 32'd1);
    n = 0;
    st = 1'b0;
    while (got.size() < exp_q.size() && n < 300) begin
      if (stall && !st && got.size() >= 4) begin
        st = 1'b1;
        tx_fifo_full = 1'b1;
        pulse_in[0] = 1'b1;
        rises[0]++;
        pulse_10ms = 1'b1;
        exp_drop++;
        @(negedge clk); #1;
        pulse_10ms = 1'b0;
        check("stall_busy", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        check("stall_no_bytes", 32'(got.size()), 32'd4);
        tx_fifo_full = 1'b0;
        pulse_in[0] = 1'b0;
        falls[0]++;
      end
      @(negedge clk); #1;
      n++;
    end
    check("frame_bytes", 32'(got.size()), 32'(exp_q.size()));
    check("busy_last", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check("busy_end", 32'(busy), 32'd0);
    check("no_extra", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size())
        check($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
    end
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    got.delete();
    exp_seq++;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_seq = 8'd0;
    exp_drop = 8'd0;
    clr_model();
    rst = 1'b0;
    ena = 1'b0;
    pulse_in = 4'd0;
    pulse_10ms = 1'b0;
    tx_fifo_full = 1'b0;
    tx_fifo_usedw = 12'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wen", 32'(tx_fifo_wen), 32'd0);
    check("rst_wdata", 32'(tx_fifo_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    ena = 1'b1;
    repeat (2) @(negedge clk);

    for (int w = 0; w < 4; w++) begin
      pulses($urandom_range(2, 8), 4'd0);
      tick(12'($urandom_range(0, 3000)));
      wait_frame(1'b0);
    end

    pulses(3, 4'd0);
    @(negedge clk); #1;
    ena = 1'b0;
    clr_model();
    repeat (3) @(negedge clk);
    #1;
    check("ena_low_busy", 32'(busy), 32'd0);
    ena = 1'b1;
    pulses(2, 4'd0);
    tick(12'd0);
    wait_frame(1'b0);

    pulses(300, 4'b0101);
    tick(12'd0);
    wait_frame(1'b0);

    @(negedge clk); #1;
    pulse_in[0] = 1'b1;
    @(negedge clk);
    tick(12'd0);
    rises[0] = 1;
    wait_frame(1'b0);
    @(negedge clk); #1;
    pulse_in[0] = 1'b0;
    falls[0]++;
    pulses(2, 4'd0);
    tick(12'd0);
    wait_frame(1'b0);

    pulses(2, 4'd0);
    tick(12'(4096 - FL + 1));
    repeat (20) @(negedge clk);
    #1;
    check("drop_no_wen", 32'(got.size()), 32'd0);
    check("drop_inc", 32'(drop_cnt), 32'(exp_drop));
    check("drop_busy", 32'(busy), 32'd0);
    pulses(2, 4'd0);
    tick(12'(4096 - FL));
    wait_frame(1'b0);

    pulses(3, 4'd0);
    tick(12'd0);
    wait_frame(1'b1);
    pulses(2, 4'd0);
    tick(12'd0);
    wait_frame(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
